// File: rtl/bcd_pkg.sv
// Shared types, constants and constant functions for the BCD converter.
package bcd_pkg;

  localparam logic [3:0] BCD_NINE = 4'h9;

  typedef logic [3:0] bcd_digit_t;

  // 10^n, wide enough for n up to 8 digits with plenty of margin.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Ceiling log2; returns 0 for x <= 1.
  function automatic int unsigned clog2(input int unsigned x);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(x)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Per-digit shift-and-add-3 correction: digits of 5 or more get +3 before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bcd_seq_conv.sv
// Iterative binary-to-BCD converter with start/busy/done handshake, overflow
// saturation to all nines and a leading-zero blank mask.
module bcd_seq_conv
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      value_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   digits_o,
  output logic [DIGITS-1:0]     blank_o,
  output logic                  overflow_o
);

  localparam int unsigned    SW        = 4 * DIGITS;
  localparam int unsigned    CntW      = clog2(WIDTH + 1);
  localparam logic [63:0]    OvfThresh = pow10(DIGITS);
  localparam logic [DIGITS-1:0] BlankRst = ~DIGITS'(1);
  localparam logic [SW-1:0]  AllNines  = {DIGITS{BCD_NINE}};

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StConv = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [SW-1:0]     scr_q, scr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_flag_q, ovf_flag_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SW-1:0]     digits_q, digits_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              overflow_q, overflow_d;

  logic [SW-1:0]     corr;
  logic [SW-1:0]     scr_shift;
  logic [DIGITS-1:0] blank_calc;
  logic              unused_corr_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (scr_q[4*g +: 4]),
      .digit_o (corr[4*g +: 4])
    );
  end

  // Top bit of the corrected scratch is shifted out and dropped.
  assign scr_shift       = {corr[SW-2:0], bin_q[WIDTH-1]};
  assign unused_corr_msb = corr[SW-1];

  // Leading-zero mask of the post-shift scratch; digit 0 is never blanked.
  always_comb begin
    logic all_zero;
    blank_calc = '0;
    all_zero   = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      all_zero      = all_zero & (scr_shift[4*i +: 4] == 4'd0);
      blank_calc[i] = all_zero;
    end
  end

  // FSM next state, datapath iteration and registered result.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    done_d     = 1'b0;
    digits_d   = digits_q;
    blank_d    = blank_q;
    overflow_d = overflow_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          bin_d      = value_i;
          scr_d      = '0;
          ovf_flag_d = (64'(value_i) >= OvfThresh);
          cnt_d      = CntW'(WIDTH);
          state_d    = StConv;
        end
      end
      StConv: begin
        scr_d = scr_shift;
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d    = StIdle;
          done_d     = 1'b1;
          overflow_d = ovf_flag_q;
          digits_d   = ovf_flag_q ? AllNines : scr_shift;
          blank_d    = ovf_flag_q ? '0 : blank_calc;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StConv);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      digits_q   <= '0;
      blank_q    <= BlankRst;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      digits_q   <= digits_d;
      blank_q    <= blank_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign digits_o   = digits_q;
  assign blank_o    = blank_q;
  assign overflow_o = overflow_q;

endmodule

// File: doc/bcd_seq_conv.md
# bcd_seq_conv

Parametrised, iterative binary-to-BCD converter (shift-and-add-3) producing DIGITS packed BCD digits from a WIDTH-bit binary value. It adds a start/busy/done handshake, overflow saturation and a leading-zero blank mask. It sits between the value source and the seven-segment digit multiplexer on the CoolRunner-II display board and supersedes the fixed 14-bit/4-digit conversion.

## Interface
- WIDTH, 14: binary input width, 1..32.
- DIGITS, 4: BCD output digits, 1..8.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request conversion of value; sampled only in IDLE.
- value  in  WIDTH  binary operand; captured on the accepted start cycle only.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; digits, blank and overflow are updated in the same cycle.
- digits  out  4*DIGITS  packed BCD; [3:0] is the least significant digit.
- blank  out  DIGITS  bit i=1 means digit i is a leading zero to be suppressed.
- overflow  out  1  last result saturated because value >= 10^DIGITS.

## Operation
- FSM states are IDLE and CONV.
- IDLE:
  - start=1 captures value into the binary shift register.
  - Clears the BCD scratch (4*DIGITS bits).
  - Computes the overflow flag as (value >= 10^DIGITS).
  - Loads iteration counter = WIDTH.
  - Moves to CONV.
- CONV, each cycle:
  - Every scratch digit >= 5 gets +3.
  - {scratch, binary} shifts left 1; binary MSB enters scratch bit 0.
  - Counter decrements.
  - When the counter reaches 1, this is the final iteration; go to IDLE.
- Final iteration result, registered:
  - digits = corrected scratch, or all 4'h9 if the overflow flag is set.
  - blank[i] = 1 iff digit i and all higher digits are 0, for i>0; blank[0] = 0 always.
  - blank = 0 on overflow.
  - overflow is set from the flag.
  - done = 1 for exactly that cycle.
- Scratch contents beyond DIGITS are not kept; after overflow, the corrupt scratch is irrelevant because output saturates.
- If 2^WIDTH <= 10^DIGITS, the overflow compare is a constant 0.
- start while busy is ignored; no queueing and no error flag.
- Outputs hold the last result until the next done; value changes after capture have no effect.
- Reset values:
  - State IDLE; busy=0, done=0, overflow=0.
  - digits=0, blank = all ones except bit 0.
  - Internal registers cleared.

## Timing
- start sampled high at edge k:
  - busy=1 after edge k.
  - WIDTH iterations at edges k+1..k+WIDTH.
  - done=1, busy=0 and new outputs after edge k+WIDTH.
- Latency is WIDTH cycles from the start edge to done (14 for defaults).
- done deasserts after the next edge.
- start high in the done cycle is accepted (FSM is IDLE), giving back-to-back throughput of one result per WIDTH+1 cycles.
- busy is registered and is the exact complement of the IDLE state.
- rst asserted mid-conversion aborts immediately to reset values. No done is produced, and the previous result is lost.
- No combinational path from inputs to outputs.

## Structure
- Shared package bcd_pkg holds:
  - Constant function pow10(n) for the overflow threshold.
  - Constant function clog2 for the counter width.
  - Localparam BCD_NINE = 4'h9.
  - Digit type (4-bit).
- One natural sub-module, bcd_add3: a combinational per-digit correction (in >= 5 ? in+3 : in), instantiated DIGITS times via generate.
- Everything else (FSM, counter, shift registers, blank/overflow logic) lives in bcd_seq_conv.

## Test plan
- Defaults, value=305, start pulse -> done 14 cycles later; digits=16'h0305, blank=4'b1000, overflow=0, busy low in the done cycle.
- Defaults, value=0 -> digits=16'h0000, blank=4'b1110. Value=9999 -> digits=16'h9999, blank=4'b0000.
- Defaults, value=10000 and value=16383 -> digits=16'h9999, blank=0, overflow=1. A following value=42 -> overflow=0, digits=16'h0042, blank=4'b1100.
- start re-asserted every cycle while busy with a different value -> ignored; result matches the first value. start held high in the done cycle -> second conversion starts, and its done comes 15 cycles after the first done.
- rst low at iteration 7 of a conversion -> all outputs at reset values immediately; no done pulse. A fresh start afterwards converts correctly.
- WIDTH=8, DIGITS=3, value=255 -> digits=12'h255, done after 8 cycles, overflow never set. Exhaustive 0..255 sweep against a reference model.
